exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception controller that sits directly downstream of the main decoder.
- Consumes the decoder's NotAnInstr and ERet flags, the current PC and an external interrupt request.
- Owns the ELR and ESR system registers and drives the PC redirect (to the exception vector, or back to ELR on ERET).
- Provides MRS read data for the system-register read path.

Parameters:
- EXC_VECTOR, 64'h0000_0000_0000_00D8, PC loaded on exception entry.
- ESR_W, 4, width of ESR.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset (reset=0 resets on rising clk).
- NotAnInstr  input  1  decoder flag: current instruction is invalid.
- ERet  input  1  decoder flag: current instruction is ERET.
- ExtIRQ  input  1  level interrupt request; source holds it until ExcAck.
- pc_in  input  64  PC of the instruction currently decoded.
- mrs_sel  input  2  system register select: 00=ELR, 01=ESR, 10=counter, 11=zero.
- EProc  output  1  redirect PC to exc_vector this cycle.
- exc_vector  output  64  constant EXC_VECTOR.
- ERetTaken  output  1  redirect PC to ELR this cycle.
- ELR  output  64  exception link register.
- ESR  output  ESR_W  exception syndrome.
- ExcAck  output  1  one-cycle IRQ acknowledge.
- InHandler  output  1  state==HANDLER.
- Halted  output  1  state==FAULT.
- sysreg_out  output  64  MRS read data (combinational from mrs_sel).

Behaviour:
- Reset values: state=IDLE, ELR=0, ESR=0, ExcAck=0, counter=0. All combinational outputs derive from these values.
- States: IDLE, HANDLER, FAULT.
- IDLE, priority order (first match wins):
  - NotAnInstr → EProc=1 (combinational, same cycle); next edge: ELR<=pc_in, ESR<=4'b0010, state<=HANDLER.
  - ERet → illegal ERET. EProc=1; next edge: ELR<=pc_in, ESR<=4'b0100, state<=HANDLER. ERetTaken stays 0.
  - ExtIRQ → EProc=1; next edge: ELR<=pc_in, ESR<=4'b0001, state<=HANDLER, ExcAck<=1 for exactly one cycle.
  - None → no change.
- HANDLER:
  - Exceptions and IRQs are masked. ExtIRQ stays pending (no ExcAck) until the controller returns to IDLE.
  - ERet → ERetTaken=1 (combinational); next edge: state<=IDLE. ELR and ESR are retained.
  - NotAnInstr (double fault) → EProc=0; next edge: ESR[3]<=1 (other bits kept), state<=FAULT.
  - If ERet and NotAnInstr are both high, NotAnInstr wins.
- FAULT:
  - Halted=1. EProc, ERetTaken and ExcAck are forced 0. All inputs are ignored.
  - Only reset leaves FAULT.
- Return and re-entry: a pending ExtIRQ is taken in the first IDLE cycle after an ERET. No bubble is inserted.
- ExcAck is registered. It is never asserted for two consecutive cycles, even if ExtIRQ stays high; the first IDLE cycle after HANDLER re-evaluates.
- Reset mid-HANDLER or in FAULT: the next edge returns everything to reset values. Any pending IRQ is re-seen afterwards.
- sysreg_out: ELR, or ESR zero-extended, or counter zero-extended, or 0, selected by mrs_sel. Reads see the current register values, not this cycle's pending updates.

Optional Feature:
- Macro: EXC_COUNT_EN.
- Defined:
  - 16-bit counter increments on every exception entry (the three IDLE entry cases).
  - Saturates at 16'hFFFF; no wrap.
  - Reset to 0.
  - Readable at mrs_sel=10.
- Undefined:
  - No counter logic.
  - mrs_sel=10 returns 0.

Test Plan:
- Reset at 0 for 2 cycles, then 1 → ELR=0, ESR=0, EProc=0, InHandler=0, Halted=0, sysreg_out=0 for all mrs_sel.
- IDLE, pc_in=64'h40, NotAnInstr=1 for one cycle → EProc=1 that cycle; next cycle ELR=64'h40, ESR=4'b0010, InHandler=1.
- From HANDLER, ERet=1 → ERetTaken=1 that cycle, then IDLE; ELR stays 64'h40.
- ExtIRQ held high while in HANDLER with pc_in=64'h80 → no ExcAck and no ELR change.
  - After ERET, the next IDLE cycle gives EProc=1; then ELR=64'h80, ESR=4'b0001, ExcAck high for exactly one cycle.
- In HANDLER with ESR=4'b0010, NotAnInstr=1 → EProc=0; then ESR=4'b1010, Halted=1.
  - Further ERet is ignored.
  - reset=0 for one cycle → IDLE with ELR=0 and ESR=0.
- EXC_COUNT_EN defined: 3 exception entries → sysreg_out with mrs_sel=10 reads 3.
  - Undefined: the same reads return 0.
  - Illegal ERET in IDLE at pc_in=64'hC → ESR=4'b0100, ELR=64'hC.

Source files
------------

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception controller: ELR/ESR ownership, PC redirect, MRS read path
// Optional EXC_COUNT_EN adds a saturating 16-bit exception-entry counter at mrs_sel=10.
module exc_ctrl #(
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
  parameter int          ESR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic             ExtIRQ,
  input  logic [63:0]      pc_in,
  input  logic [1:0]       mrs_sel,
  output logic             EProc,
  output logic [63:0]      exc_vector,
  output logic             ERetTaken,
  output logic [63:0]      ELR,
  output logic [ESR_W-1:0] ESR,
  output logic             ExcAck,
  output logic             InHandler,
  output logic             Halted,
  output logic [63:0]      sysreg_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, HANDLER = 2'd1, FAULT = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [63:0]      elr_nxt;
  logic [ESR_W-1:0] esr_nxt;
  logic             ack_nxt;
  logic             entry;

  assign exc_vector = EXC_VECTOR;
  assign InHandler  = (state == HANDLER);
  assign Halted     = (state == FAULT);

  always_comb begin
    state_nxt = state;
    elr_nxt   = ELR;
    esr_nxt   = ESR;
    ack_nxt   = 1'b0;
    entry     = 1'b0;
    EProc     = 1'b0;
    ERetTaken = 1'b0;
    case (state)
      IDLE: begin
        // Priority: invalid instruction, then illegal ERET, then interrupt.
        if (NotAnInstr || ERet || ExtIRQ) begin
          EProc     = 1'b1;
          entry     = 1'b1;
          elr_nxt   = pc_in;
          state_nxt = HANDLER;
          esr_nxt   = '0;
          if (NotAnInstr)  esr_nxt[1] = 1'b1;
          else if (ERet)   esr_nxt[2] = 1'b1;
          else begin
            esr_nxt[0] = 1'b1;
            ack_nxt    = 1'b1;
          end
        end
      end
      HANDLER: begin
        // Double fault outranks a return; IRQs stay pending until IDLE.
        if (NotAnInstr) begin
          esr_nxt[3] = 1'b1;
          state_nxt  = FAULT;
        end else if (ERet) begin
          ERetTaken = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      ELR    <= '0;
      ESR    <= '0;
      ExcAck <= 1'b0;
    end else begin
      state  <= state_nxt;
      ELR    <= elr_nxt;
      ESR    <= esr_nxt;
      ExcAck <= ack_nxt;
    end
  end

`ifdef EXC_COUNT_EN
  logic [15:0] exc_cnt;

  always_ff @(posedge clk) begin
    if (!reset)                            exc_cnt <= '0;
    else if (entry && exc_cnt != 16'hFFFF) exc_cnt <= exc_cnt + 16'd1;
  end

  always_comb begin
    case (mrs_sel)
      2'b00:   sysreg_out = ELR;
      2'b01:   sysreg_out = {{(64-ESR_W){1'b0}}, ESR};
      2'b10:   sysreg_out = {48'd0, exc_cnt};
      default: sysreg_out = 64'd0;
    endcase
  end
`else
  logic unused_entry;
  assign unused_entry = entry;

  always_comb begin
    case (mrs_sel)
      2'b00:   sysreg_out = ELR;
      2'b01:   sysreg_out = {{(64-ESR_W){1'b0}}, ESR};
      default: sysreg_out = 64'd0;
    endcase
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        NotAnInstr, ERet, ExtIRQ;
  logic [63:0] pc_in;
  logic [1:0]  mrs_sel;
  logic        EProc, ERetTaken, ExcAck, InHandler, Halted;
  logic [63:0] exc_vector, ELR, sysreg_out;
  logic [3:0]  ESR;

  int checks = 0;
  int errors = 0;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .NotAnInstr(NotAnInstr), .ERet(ERet), .ExtIRQ(ExtIRQ),
    .pc_in(pc_in), .mrs_sel(mrs_sel), .EProc(EProc), .exc_vector(exc_vector),
    .ERetTaken(ERetTaken), .ELR(ELR), .ESR(ESR), .ExcAck(ExcAck),
    .InHandler(InHandler), .Halted(Halted), .sysreg_out(sysreg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_sys(input string tag, input logic [1:0] sel, input logic [63:0] exp);
    mrs_sel = sel;
    #1;
    check(tag, sysreg_out, exp);
  endtask

  logic [63:0] cnt3, cnt4;

  initial begin
`ifdef EXC_COUNT_EN
    cnt3 = 64'd3;
    cnt4 = 64'd4;
`else
    cnt3 = 64'd0;
    cnt4 = 64'd0;
`endif
    reset = 1'b0; NotAnInstr = 1'b0; ERet = 1'b0; ExtIRQ = 1'b0;
    pc_in = 64'h0; mrs_sel = 2'b00;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_elr", ELR, 64'h0);
    check("rst_esr", ESR, 4'h0);
    check("rst_eproc", EProc, 1'b0);
    check("rst_inh", InHandler, 1'b0);
    check("rst_halt", Halted, 1'b0);
    check("rst_ack", ExcAck, 1'b0);
    check("vector", exc_vector, 64'hD8);
    for (int s = 0; s < 4; s++) read_sys("rst_sys", 2'(s), 64'h0);

    // Invalid instruction at 0x40
    pc_in = 64'h40; NotAnInstr = 1'b1; #1;
    check("nai_eproc", EProc, 1'b1);
    tick(); NotAnInstr = 1'b0; #1;
    check("nai_elr", ELR, 64'h40);
    check("nai_esr", ESR, 4'b0010);
    check("nai_inh", InHandler, 1'b1);

    // Return
    ERet = 1'b1; #1;
    check("eret_taken", ERetTaken, 1'b1);
    check("eret_eproc", EProc, 1'b0);
    tick(); ERet = 1'b0; #1;
    check("eret_idle", InHandler, 1'b0);
    check("eret_elr", ELR, 64'h40);

    // Re-enter, then hold IRQ while in handler
    pc_in = 64'h50; NotAnInstr = 1'b1;
    tick(); NotAnInstr = 1'b0;
    pc_in = 64'h80; ExtIRQ = 1'b1; #1;
    check("mask_eproc", EProc, 1'b0);
    tick();
    check("mask_ack", ExcAck, 1'b0);
    check("mask_elr", ELR, 64'h50);
    ERet = 1'b1; #1;
    check("eret2_taken", ERetTaken, 1'b1);
    tick(); ERet = 1'b0; #1;
    check("irq_eproc", EProc, 1'b1);
    check("irq_ack_pre", ExcAck, 1'b0);
    tick();
    check("irq_elr", ELR, 64'h80);
    check("irq_esr", ESR, 4'b0001);
    check("irq_ack", ExcAck, 1'b1);
    tick();
    check("irq_ack_once", ExcAck, 1'b0);
    ExtIRQ = 1'b0;
    read_sys("sys_cnt3", 2'b10, cnt3);
    read_sys("sys_elr", 2'b00, 64'h80);
    read_sys("sys_esr", 2'b01, 64'h1);

    // Back to IDLE, enter via invalid instruction, then double fault
    ERet = 1'b1; tick(); ERet = 1'b0;
    pc_in = 64'h60; NotAnInstr = 1'b1; tick();
    check("df_pre_esr", ESR, 4'b0010);
    #1;
    check("df_eproc", EProc, 1'b0);
    tick(); NotAnInstr = 1'b0; #1;
    check("df_esr", ESR, 4'b1010);
    check("df_halt", Halted, 1'b1);
    check("df_inh", InHandler, 1'b0);
    ERet = 1'b1; ExtIRQ = 1'b1; #1;
    check("flt_eret", ERetTaken, 1'b0);
    check("flt_eproc", EProc, 1'b0);
    tick();
    check("flt_stay", Halted, 1'b1);
    check("flt_ack", ExcAck, 1'b0);
    check("flt_elr", ELR, 64'h60);
    ERet = 1'b0; ExtIRQ = 1'b0;
    read_sys("sys_cnt4", 2'b10, cnt4);

    // Reset out of FAULT
    reset = 1'b0; tick(); reset = 1'b1; #1;
    check("rst2_halt", Halted, 1'b0);
    check("rst2_elr", ELR, 64'h0);
    check("rst2_esr", ESR, 4'h0);
    read_sys("rst2_cnt", 2'b10, 64'h0);

    // Illegal ERET in IDLE
    pc_in = 64'hC; ERet = 1'b1; #1;
    check("ill_eproc", EProc, 1'b1);
    check("ill_taken", ERetTaken, 1'b0);
    tick(); ERet = 1'b0; #1;
    check("ill_esr", ESR, 4'b0100);
    check("ill_elr", ELR, 64'hC);
    check("ill_ack", ExcAck, 1'b0);

    // Priority: NotAnInstr and ERet together in HANDLER -> FAULT
    NotAnInstr = 1'b1; ERet = 1'b1; #1;
    check("pri_taken", ERetTaken, 1'b0);
    tick(); NotAnInstr = 1'b0; ERet = 1'b0; #1;
    check("pri_halt", Halted, 1'b1);
    check("pri_esr", ESR, 4'b1100);

    // Priority in IDLE: NotAnInstr beats ExtIRQ, no acknowledge
    reset = 1'b0; tick(); reset = 1'b1;
    pc_in = 64'h90; NotAnInstr = 1'b1; ExtIRQ = 1'b1;
    tick(); NotAnInstr = 1'b0; ExtIRQ = 1'b0; #1;
    check("pri2_esr", ESR, 4'b0010);
    check("pri2_ack", ExcAck, 1'b0);
    check("pri2_elr", ELR, 64'h90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
